// File: rtl/seq_branch_comparator_pkg.sv
// seq_branch_comparator_pkg
// Shared definitions for the stage-2 branch compare datapath: branch condition
// (funct3) encodings, the comparator FSM state encoding, and the helper that
// turns lt/eq into a branch decision.
package seq_branch_comparator_pkg;

  localparam logic [2:0] COND_BEQ  = 3'b000;
  localparam logic [2:0] COND_BNE  = 3'b001;
  localparam logic [2:0] COND_BLT  = 3'b100;
  localparam logic [2:0] COND_BGE  = 3'b101;
  localparam logic [2:0] COND_BLTU = 3'b110;
  localparam logic [2:0] COND_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved encodings (010/011) never take the branch.
  function automatic logic branch_taken(input logic [2:0] cond,
                                        input logic       lt,
                                        input logic       eq);
    logic t;
    t = 1'b0;
    case (cond)
      COND_BEQ:             t = eq;
      COND_BNE:             t = ~eq;
      COND_BLT, COND_BLTU:  t = lt;
      COND_BGE, COND_BGEU:  t = ~lt;
      default:              t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/seq_branch_comparator_chunk_compare.sv
// chunk_compare
// Purely combinational unsigned comparison of one CHUNK-wide slice.
// Ports:
//   a, b : CHUNK-bit operand slices
//   eq   : a == b
//   lt   : a <  b (unsigned)
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_branch_comparator.sv
// seq_branch_comparator
// Multi-cycle branch comparator. Operands are captured on accept and compared
// CHUNK bits per cycle, most significant chunk first, stopping at the first
// differing chunk. The result is held until the consumer takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : abort any operation in progress (beats in_valid/out_ready)
//   in_valid, in_ready  : request handshake (in_ready only while idle)
//   rs1d, rs2d, s, cond : operands, generic signed flag, branch funct3
//   out_valid, out_ready: result handshake
//   lt, eq, taken       : compare results and branch decision (0 unless out_valid)
module seq_branch_comparator
  import seq_branch_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic             s,
  input  logic [2:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             taken
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cond_q;
  logic [IDX_W-1:0] idx_q;
  logic             lt_q, eq_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_eq, chunk_lt;
  logic             eff_sign;
  logic             accept;
  logic             cmp_active;

  // Conditional branches carry their own signedness in funct3; only the
  // generic (BEQ/BNE/reserved) encodings use the external s flag.
  assign eff_sign   = cond[2] ? ~cond[1] : s;
  assign accept     = (state_q == ST_IDLE) && in_valid && !flush;
  assign cmp_active = (state_q == ST_CMP) && !flush;

  assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a  (a_chunk),
    .b  (b_chunk),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (!chunk_eq || idx_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
    lt    = out_valid & lt_q;
    eq    = out_valid & eq_q;
    taken = out_valid & branch_taken(cond_q, lt_q, eq_q);
  end

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the per-chunk unsigned compare handles both cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cond_q <= '0;
      idx_q  <= '0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= {rs1d[WIDTH-1] ^ eff_sign, rs1d[WIDTH-2:0]};
      b_q    <= {rs2d[WIDTH-1] ^ eff_sign, rs2d[WIDTH-2:0]};
      cond_q <= cond;
      idx_q  <= IDX_LAST;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else if (cmp_active) begin
      if (!chunk_eq) begin
        lt_q <= chunk_lt;
        eq_q <= 1'b0;
      end else if (idx_q == '0) begin
        lt_q <= 1'b0;
        eq_q <= 1'b1;
      end else begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_branch_comparator.sv
// tb_seq_branch_comparator
// Directed bench for seq_branch_comparator (WIDTH=32, CHUNK=8). Expected
// results come from a behavioural model and are queued when a request is
// driven, then popped when the DUT presents its result.
module tb_seq_branch_comparator;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1d;
  logic [WIDTH-1:0] rs2d;
  logic             s;
  logic [2:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             taken;

  typedef struct {
    logic lt;
    logic eq;
    logic taken;
    int   lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_assert = 0;
  int   n_fail   = 0;

  seq_branch_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1d      (rs1d),
    .rs2d      (rs2d),
    .s         (s),
    .cond      (cond),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .taken     (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sg);
    exp_t e;
    logic sgn;
    logic found;
    sgn   = c[2] ? ~c[1] : sg;
    e.eq  = (a == b);
    e.lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    e.lat = N;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!found && a[k*CHUNK +: CHUNK] != b[k*CHUNK +: CHUNK]) begin
        e.lat = N - k;
        found = 1'b1;
      end
    end
    case (c)
      3'b000:         e.taken = e.eq;
      3'b001:         e.taken = ~e.eq;
      3'b100, 3'b110: e.taken = e.lt;
      3'b101, 3'b111: e.taken = ~e.lt;
      default:        e.taken = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one request for a single cycle; caller ensures the DUT is idle.
  task automatic apply_stimulus(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic sg,
                                input bit push);
    cond     = c;
    rs1d     = a;
    rs2d     = b;
    s        = sg;
    in_valid = 1'b1;
    if (push) sb.push_back(model(c, a, b, sg));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid and compares latency and results.
  task automatic check_output(input string tag);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      seen = out_valid;
    end
    if (sb.size() == 0) begin
      check({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      last_exp = sb.pop_front();
      check({tag, "/latency"}, seen ? cyc : 999, last_exp.lat);
      check({tag, "/lt"}, lt, last_exp.lt);
      check({tag, "/eq"}, eq, last_exp.eq);
      check({tag, "/taken"}, taken, last_exp.taken);
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/handoff_out_valid"}, out_valid, 1'b0);
    check({tag, "/handoff_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    bit pulsed;
    pulsed = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulsed = 1'b1;
    end
    check({tag, "/no_out_valid"}, pulsed, 1'b0);
    check({tag, "/idle"}, in_ready, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/in_ready"}, in_ready, 1'b1);
    check({tag, "/out_valid"}, out_valid, 1'b0);
    check({tag, "/lt_eq_taken"}, {lt, eq, taken}, 3'b000);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    rs1d      = '0;
    rs2d      = '0;
    s         = 1'b0;
    cond      = 3'b000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("reset");

    apply_stimulus(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check_output("blt_neg");
    handoff("blt_neg");

    apply_stimulus(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check_output("bltu");
    handoff("bltu");

    apply_stimulus(3'b000, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    check_output("beq_equal");
    handoff("beq_equal");

    apply_stimulus(3'b001, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1);
    check_output("bne_lsb");
    handoff("bne_lsb");

    apply_stimulus(3'b010, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1);
    check_output("reserved");
    handoff("reserved");

    apply_stimulus(3'b101, 32'h0012_0000, 32'h0034_0000, 1'b0, 1'b1);
    check_output("bge_chunk2");
    handoff("bge_chunk2");

    apply_stimulus(3'b111, 32'h8000_AB00, 32'h8000_1200, 1'b0, 1'b1);
    check_output("bgeu_chunk1");
    handoff("bgeu_chunk1");

    apply_stimulus(3'b000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    check_output("beq_generic_signed");
    handoff("beq_generic_signed");

    apply_stimulus(3'b000, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    check_output("beq_generic_unsigned");
    handoff("beq_generic_unsigned");

    // Requests presented while comparing must be ignored.
    apply_stimulus(3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b1);
    cond     = 3'b100;
    rs1d     = 32'h0000_0001;
    rs2d     = 32'h7000_0000;
    in_valid = 1'b1;
    check_output("ignore_in_cmp");
    in_valid = 1'b0;
    handoff("ignore_in_cmp");

    // Backpressure: result held for three cycles with a competing request.
    out_ready = 1'b0;
    apply_stimulus(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    check_output("bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      cond     = 3'b001;
      rs1d     = $urandom;
      rs2d     = $urandom;
      @(posedge clk); #1;
      check("bp/hold_out_valid", out_valid, 1'b1);
      check("bp/hold_lt", lt, last_exp.lt);
      check("bp/hold_eq", eq, last_exp.eq);
      check("bp/hold_taken", taken, last_exp.taken);
      check("bp/hold_in_ready", in_ready, 1'b0);
    end
    handoff("bp");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp/not_accepted", in_ready, 1'b1);

    // Flush on the second compare cycle of an equal-operand request.
    apply_stimulus(3'b000, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle_outputs("flush_cmp");
    expect_silence("flush_cmp", 6);

    // Reset on the second compare cycle behaves the same way.
    apply_stimulus(3'b000, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst   = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    flush = 1'b0;
    check_idle_outputs("rst_cmp");
    expect_silence("rst_cmp", 6);

    // Flush alongside a request in idle blocks the accept.
    cond     = 3'b000;
    rs1d     = 32'h1111_1111;
    rs2d     = 32'h1111_1111;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_idle_outputs("flush_idle");
    expect_silence("flush_idle", 6);

    // Normal operation resumes after the aborts.
    apply_stimulus(3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check_output("bge_after_abort");
    handoff("bge_after_abort");

    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_branch_comparator.md
SEQ_BRANCH_COMPARATOR -- requirements
Module: seq_branch_comparator

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any operation in progress.
REQ-006 in_valid  input  1  request present; in_ready  output  1  block can accept a request.
REQ-007 rs1d, rs2d  input  WIDTH  operands; s  input  1  signed compare for generic conditions.
REQ-008 cond  input  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 reserved.
REQ-009 out_valid  output  1  result present; out_ready  input  1  consumer accepts result.
REQ-010 lt, eq, taken  output  1 each  compare results and branch decision.

Function
REQ-011 FSM states: IDLE, CMP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 IDLE: in_valid=1 and flush=0 SHALL capture rs1d, rs2d, cond and effective sign, load chunk index N-1, and go to CMP.
REQ-013 Effective sign SHALL be ~cond[1] when cond[2]=1, else s.
REQ-014 Signed compare SHALL be implemented by inverting bit WIDTH-1 of both captured operands, then comparing unsigned.
REQ-015 CMP: each cycle SHALL compare one chunk, MSB chunk first, index decrementing.
REQ-016 A differing chunk SHALL set lt = (rs1 chunk < rs2 chunk), set eq=0, and go to DONE; remaining chunks are skipped (early exit).
REQ-017 An equal chunk 0 SHALL set eq=1, lt=0 and go to DONE.
REQ-018 Latency: out_valid SHALL assert k cycles after the accept edge, where k = N - j and j is the index of the highest differing chunk; k = N when the operands are equal.
REQ-019 taken SHALL be: BEQ eq; BNE ~eq; BLT/BLTU lt; BGE/BGEU ~lt; reserved 0.
REQ-020 DONE: out_valid=1; lt, eq and taken SHALL hold stable until out_valid and out_ready are both 1, then the FSM SHALL go to IDLE.
REQ-021 No request SHALL be accepted in the cycle of result handoff; the next accept is at the earliest one cycle later.
REQ-022 Requests presented outside IDLE SHALL be ignored, with no side effects.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge and discard any result; flush SHALL take priority over in_valid and out_ready.
REQ-024 out_valid SHALL be 0 in IDLE and CMP; lt, eq and taken SHALL be 0 whenever out_valid=0.

Reset
REQ-025 rst SHALL take priority over flush and all other inputs.
REQ-026 The cycle after rst: state IDLE, in_ready=1, out_valid=0, lt=eq=taken=0, chunk index 0, captured operands 0.
REQ-027 rst mid-CMP or in DONE SHALL drop the operation silently, with no out_valid pulse.

Structure
REQ-028 Branch cond encodings and FSM state encodings SHALL live in the shared package/header used by the stage-2 datapath.
REQ-029 One combinational sub-module, chunk_compare (CHUNK-wide, outputs eq and lt), SHALL be instantiated once and muxed by chunk index.
REQ-030 The RTL SHALL contain no multicycle paths; the critical path is one CHUNK compare plus the chunk mux.

Verification (WIDTH=32, CHUNK=8)
REQ-031 BLT with rs1d=0xFFFFFFFF, rs2d=0x00000001 -> out_valid 1 cycle after accept; lt=1, eq=0, taken=1.
REQ-032 BLTU with the same operands -> out_valid 1 cycle after accept; lt=0, eq=0, taken=0.
REQ-033 BEQ with 0x12345678 vs 0x12345678 -> out_valid 4 cycles after accept; eq=1, lt=0, taken=1.
REQ-034 BNE with 0x12345678 vs 0x12345679 -> out_valid 4 cycles after accept; lt=1, eq=0, taken=1; cond=010 with the same operands -> taken=0.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new request not accepted; handoff on the 4th cycle, in_ready=1 the cycle after.
REQ-036 Abort: assert flush (then, separately, rst) on the 2nd CMP cycle of REQ-033 -> IDLE next cycle, out_valid never asserts; flush with in_valid=1 in IDLE -> no accept.
